z_event_counter: RTL and testbench
==================================

Name: z_event_counter

Overview:
- Downstream consumer of the two-input gate output z.
- Synchronises and debounces z into z_clean, then counts its rising edges in a saturating counter.
- Offers a valid/ready snapshot port so a host or bench can read the count without tearing.
- Fills the gap between raw gate output and any register or logging stage in the project.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on z_in; legal range 2..4
DEBOUNCE, 4, consecutive mismatching samples required before z_clean changes; legal range 1..255
CNT_W, 8, width of the event counter and of rd_data

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
z_in  in  1  raw z from the gate stage; asynchronous to clk
clear  in  1  synchronous clear of count, sat and snap_ovr
snap_req  in  1  single-cycle request to capture count
rd_ready  in  1  consumer ready for rd_data
z_clean  out  1  synchronised, debounced z
rise_pulse  out  1  one-cycle pulse on each z_clean 0->1 transition
count  out  CNT_W  live event count
sat  out  1  sticky flag: count reached 2^CNT_W-1
rd_valid  out  1  rd_data holds a captured snapshot
rd_data  out  CNT_W  captured count
snap_ovr  out  1  sticky flag: a snap_req was lost

Behaviour:
- Reset (rst_n=0, immediate and asynchronous):
  - synchroniser flops=0, stab_cnt=0, z_clean=0, rise_pulse=0, count=0, sat=0.
  - rd_valid=0, rd_data=0, snap_ovr=0, FSM=IDLE.
  - Assertion mid-handshake discards the snapshot. Release is synchronous-safe; first update is on the first edge after deassertion.
- Synchroniser: SYNC_STAGES-deep shift register; z_sync is the last stage.
- Debounce:
  - If z_sync==z_clean, stab_cnt<=0.
  - Otherwise stab_cnt increments. On the edge where stab_cnt==DEBOUNCE-1, z_clean<=z_sync and stab_cnt<=0.
  - A glitch shorter than DEBOUNCE samples never reaches z_clean.
- Latency: z_in changes before edge 1 and holds → z_clean changes at edge SYNC_STAGES+DEBOUNCE (edge 6 at defaults).
- rise_pulse: registered, high for exactly the cycle after z_clean goes 0->1 is sampled, i.e. same edge as z_clean rises. Never high on a 1->0 transition.
- Counter: on the same edge as rise_pulse rises, count<=count+1 unless count==2^CNT_W-1.
  - At max, count holds and sat<=1.
  - sat is sticky until clear or reset.
  - sat is also set on the edge count becomes max.
- clear: count<=0, sat<=0, snap_ovr<=0 on that edge.
  - clear beats a coincident increment: the event is dropped and count=0.
  - clear does not affect z_clean, the FSM, rd_valid or rd_data.
- Snapshot FSM, states IDLE and HOLD:
  - IDLE, snap_req=1: rd_data<=count (registered value before any same-edge increment), rd_valid<=1, go to HOLD.
  - HOLD, rd_ready=1 and snap_req=0: rd_valid<=0, go to IDLE.
  - HOLD, rd_ready=1 and snap_req=1: transfer completes, rd_data reloads with current count, rd_valid stays 1, stay in HOLD (back-to-back, no bubble).
  - HOLD, rd_ready=0 and snap_req=1: request dropped, snap_ovr<=1, rd_data unchanged.
  - rd_data and rd_valid are stable while rd_valid=1 and rd_ready=0.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package z_pkg:
  - default constants Z_SYNC_STAGES=2, Z_DEBOUNCE=4, Z_CNT_W=8.
  - FSM state enum snap_state_t {IDLE, HOLD}.
- One sub-module z_debounce (synchroniser + stab_cnt + z_clean + rise_pulse), parameterised by SYNC_STAGES and DEBOUNCE.
- Counter and snapshot FSM live in the top.

Test Plan:
- Reset then z_in=0 for 20 cycles → z_clean=0, count=0, rd_valid=0, all flags 0.
- z_in 0->1 before edge 1 and held → z_clean=1 and rise_pulse=1 at edge 6 only, count=1 at edge 6. z_in 1->0 later → no pulse, count stays 1.
- z_in high for 3 cycles then low (glitch < DEBOUNCE) → z_clean stays 0, count stays 0. Repeat with 4-cycle pulse → count=1.
- CNT_W=4, 17 clean pulses → count=15 and sat=1 after 15th. Then clear coincident with a rise → count=0, sat=0.
- count=5, snap_req with rd_ready=0 → rd_valid=1, rd_data=5. Two more pulses and a second snap_req → snap_ovr=1, rd_data still 5. rd_ready=1 → rd_valid=0 next edge.
- In HOLD with rd_data=5 and count=7, rd_ready=1 and snap_req=1 → rd_valid stays 1, rd_data=7. Then rst_n=0 mid-HOLD → all outputs 0 immediately.

Source files
------------

// File: rtl/z_pkg.sv
// Shared constants and types for the z event-counter slice.
// Default parameters and the snapshot handshake state encoding live here.
package z_pkg;

    localparam int Z_SYNC_STAGES = 2;
    localparam int Z_DEBOUNCE    = 4;
    localparam int Z_CNT_W       = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_t;

endpackage

// File: rtl/z_debounce.sv
// Synchronises the asynchronous z input, debounces it into z_clean and
// flags each accepted rising transition.
module z_debounce
    import z_pkg::*;
#(
    parameter int SYNC_STAGES = Z_SYNC_STAGES,
    parameter int DEBOUNCE    = Z_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic z_in,
    output logic z_clean,
    output logic rise_pulse,
    output logic rise_evt
);

    localparam logic [7:0] STAB_LAST = 8'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   z_sync;
    logic [7:0]             stab_cnt_q, stab_cnt_d;
    logic                   z_clean_q, z_clean_d;
    logic                   rise_pulse_q;

    assign z_sync = sync_q[SYNC_STAGES-1];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        z_clean_d  = z_clean_q;
        if (z_sync == z_clean_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
            stab_cnt_d = '0;
            z_clean_d  = z_sync;
        end else begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    // Built from registered state only, so the top may count on the same edge.
    assign rise_evt = z_sync & ~z_clean_q & (stab_cnt_q == STAB_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            stab_cnt_q   <= '0;
            z_clean_q    <= 1'b0;
            rise_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], z_in};
            stab_cnt_q   <= stab_cnt_d;
            z_clean_q    <= z_clean_d;
            rise_pulse_q <= rise_evt;
        end
    end

    assign z_clean    = z_clean_q;
    assign rise_pulse = rise_pulse_q;

endmodule

// File: rtl/z_event_counter.sv
// Counts debounced rising edges of z in a saturating counter and exposes
// a tear-free valid/ready snapshot of the count.
module z_event_counter
    import z_pkg::*;
#(
    parameter int SYNC_STAGES = Z_SYNC_STAGES,
    parameter int DEBOUNCE    = Z_DEBOUNCE,
    parameter int CNT_W       = Z_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    input  logic             clear,
    input  logic             snap_req,
    input  logic             rd_ready,
    output logic             z_clean,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             snap_ovr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             rise_evt;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    snap_state_t      state_q, state_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             snap_ovr_q, snap_ovr_d;
    logic             ovr_set;

    z_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .z_in       (z_in),
        .z_clean    (z_clean),
        .rise_pulse (rise_pulse),
        .rise_evt   (rise_evt)
    );

    // clear wins over a coincident event; sat also sets on the edge count reaches max.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (rise_evt) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
            if (count_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snap_req) state_d = HOLD;
            HOLD:    if (rd_ready && !snap_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshots take the registered count, i.e. the value before any same-edge increment.
    always_comb begin
        rd_data_d = rd_data_q;
        ovr_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) rd_data_d = count_q;
            end
            HOLD: begin
                if (rd_ready && snap_req) rd_data_d = count_q;
                else if (!rd_ready && snap_req) ovr_set = 1'b1;
            end
            default: ;
        endcase
        if (clear)        snap_ovr_d = 1'b0;
        else if (ovr_set) snap_ovr_d = 1'b1;
        else              snap_ovr_d = snap_ovr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            sat_q      <= 1'b0;
            state_q    <= IDLE;
            rd_data_q  <= '0;
            snap_ovr_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sat_q      <= sat_d;
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            snap_ovr_q <= snap_ovr_d;
        end
    end

    assign count    = count_q;
    assign sat      = sat_q;
    assign rd_valid = (state_q == HOLD);
    assign rd_data  = rd_data_q;
    assign snap_ovr = snap_ovr_q;

endmodule

// File: tb/tb_z_event_counter.sv
// Randomised and directed bench for z_event_counter: two instances (8-bit and
// 4-bit counters) share stimulus and are checked against a behavioural model.
module tb_z_event_counter;

    localparam int S   = 2;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic z_in = 1'b0, clear = 1'b0, snap_req = 1'b0, rd_ready = 1'b0;

    logic       zc8, rp8, sat8, rv8, ovr8;
    logic [7:0] cnt8, rd8;
    logic       zc4, rp4, sat4, rv4, ovr4;
    logic [3:0] cnt4, rd4;

    always #5 clk = ~clk;

    z_event_counter #(.SYNC_STAGES(S), .DEBOUNCE(DEB), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .clear(clear), .snap_req(snap_req),
        .rd_ready(rd_ready), .z_clean(zc8), .rise_pulse(rp8), .count(cnt8), .sat(sat8),
        .rd_valid(rv8), .rd_data(rd8), .snap_ovr(ovr8)
    );

    z_event_counter #(.SYNC_STAGES(S), .DEBOUNCE(DEB), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .clear(clear), .snap_req(snap_req),
        .rd_ready(rd_ready), .z_clean(zc4), .rise_pulse(rp4), .count(cnt4), .sat(sat4),
        .rd_valid(rv4), .rd_data(rd4), .snap_ovr(ovr4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: z_sync is z_in seen SYNC_STAGES edges late; z_clean flips
    // after DEBOUNCE consecutive disagreeing samples.
    bit zq[$];
    bit m_clean, m_pulse;
    int m_run;
    int m_max[2] = '{255, 15};
    int m_cnt[2], m_data[2];
    bit m_sat[2], m_hold[2], m_ovr[2];

    task automatic model_reset();
        zq.delete();
        for (int i = 0; i < S; i++) zq.push_back(1'b0);
        m_clean = 0; m_pulse = 0; m_run = 0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_data[i] = 0; m_sat[i] = 0; m_hold[i] = 0; m_ovr[i] = 0;
        end
    endtask

    task automatic model_step();
        bit zs, rise;
        int old;
        zs = zq.pop_front();
        zq.push_back(z_in);
        rise = 0;
        if (zs == m_clean) m_run = 0;
        else begin
            m_run++;
            if (m_run == DEB) begin
                m_clean = zs;
                m_run   = 0;
                rise    = zs;
            end
        end
        m_pulse = rise;
        for (int i = 0; i < 2; i++) begin
            old = m_cnt[i];
            if (!m_hold[i]) begin
                if (snap_req) begin m_data[i] = old; m_hold[i] = 1; end
            end else if (rd_ready) begin
                if (snap_req) m_data[i] = old;
                else m_hold[i] = 0;
            end else if (snap_req) m_ovr[i] = 1;
            if (clear) begin
                m_cnt[i] = 0; m_sat[i] = 0; m_ovr[i] = 0;
            end else if (rise) begin
                if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                if (m_cnt[i] == m_max[i]) m_sat[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("z_clean8", zc8, m_clean);    check("rise8", rp8, m_pulse);
        check("count8", cnt8, m_cnt[0]);    check("sat8", sat8, m_sat[0]);
        check("rd_valid8", rv8, m_hold[0]); check("rd_data8", rd8, m_data[0]);
        check("ovr8", ovr8, m_ovr[0]);
        check("z_clean4", zc4, m_clean);    check("rise4", rp4, m_pulse);
        check("count4", cnt4, m_cnt[1]);    check("sat4", sat4, m_sat[1]);
        check("rd_valid4", rv4, m_hold[1]); check("rd_data4", rd4, m_data[1]);
        check("ovr4", ovr4, m_ovr[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; z_in = 0; clear = 0; snap_req = 0; rd_ready = 0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    task automatic pulse(input int hi, input int lo);
        z_in = 1;
        repeat (hi) cycle();
        z_in = 0;
        repeat (lo) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_zc"}, {zc8, zc4, rp8, rp4}, 0);
        check({tag, "_cnt"}, {cnt8, cnt4}, 0);
        check({tag, "_flags"}, {sat8, sat4, rv8, rv4, ovr8, ovr4}, 0);
        check({tag, "_rd"}, {rd8, rd4}, 0);
    endtask

    initial begin
        int run;
        model_reset();
        do_reset();
        check_all_zero("reset");

        repeat (20) cycle();
        check_all_zero("idle20");

        // Latency: z_clean and rise_pulse at edge SYNC_STAGES+DEBOUNCE only
        z_in = 1;
        for (int e = 1; e <= 8; e++) begin
            cycle();
            check("lat_zclean", zc8, (e >= S + DEB) ? 1 : 0);
            check("lat_pulse", rp8, (e == S + DEB) ? 1 : 0);
        end
        check("lat_count", cnt8, 1);
        z_in = 0;
        for (int e = 1; e <= 10; e++) begin
            cycle();
            check("fall_nopulse", rp8, 0);
        end
        check("fall_zclean", zc8, 0);
        check("fall_count", cnt8, 1);

        // Glitch shorter than DEBOUNCE is filtered; DEBOUNCE-long pulse counts
        do_reset();
        pulse(DEB - 1, 12);
        check("glitch_count", cnt8, 0);
        pulse(DEB, 12);
        check("min_pulse_count", cnt8, 1);

        // Saturation on the 4-bit instance
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            pulse(6, 6);
            check("sat_count4", cnt4, (i < 15) ? i : 15);
            check("sat_flag4", sat4, (i >= 15) ? 1 : 0);
            check("sat_count8", cnt8, i);
        end
        z_in = 1;
        repeat (S + DEB - 1) cycle();
        clear = 1;
        cycle();
        clear = 0;
        check("clr_pulse", rp4, 1);
        check("clr_count4", cnt4, 0);
        check("clr_sat4", sat4, 0);
        check("clr_count8", cnt8, 0);
        z_in = 0;
        repeat (8) cycle();

        // Snapshot handshake
        do_reset();
        repeat (5) pulse(6, 6);
        snap_req = 1; cycle(); snap_req = 0;
        check("snap_valid", rv8, 1);
        check("snap_data", rd8, 5);
        repeat (2) pulse(6, 6);
        snap_req = 1; cycle(); snap_req = 0;
        check("ovr_flag", ovr8, 1);
        check("ovr_data", rd8, 5);
        check("ovr_count", cnt8, 7);
        rd_ready = 1; snap_req = 1; cycle(); snap_req = 0; rd_ready = 0;
        check("b2b_valid", rv8, 1);
        check("b2b_data", rd8, 7);
        rd_ready = 1; cycle(); rd_ready = 0;
        check("drain_valid", rv8, 0);
        snap_req = 1; cycle(); snap_req = 0;
        check("hold_again", rv8, 1);
        #2 rst_n = 0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        model_reset();
        rst_n = 1;

        // Randomised traffic against the model
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                z_in = ~z_in;
                run  = $urandom_range(1, 9);
            end
            run--;
            snap_req = ($urandom_range(0, 3) == 0);
            rd_ready = $urandom_range(0, 1);
            clear    = ($urandom_range(0, 399) == 0);
            cycle();
        end
        clear = 0; snap_req = 0; rd_ready = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
